// File: rtl/byte_striping_pkg.sv
// Shared definitions for the byte striping sequencer: FSM encoding and
// striping defaults used by the controller and its testbench.
package byte_striping_pkg;

  // Controller states; PAD completes a partial 4-byte group with filler.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PAD    = 2'd2
  } state_e;

  // Default number of striping lanes (fixed at 4 in this revision).
  localparam int LANES_DEF = 4;

  // Width of the lane pointer for four lanes.
  localparam int LANE_W = 2;

  // Filler byte used to finish a partial group.
  localparam logic [7:0] PAD_BYTE_DEF = 8'hBC;

endpackage : byte_striping_pkg

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter: picks the first active request
// searching upward from the index after the last grant, wrapping modulo
// NUM_REQ. any_req flags that at least one request is present.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int REQ_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   last_grant,
  output logic [REQ_W-1:0]   grant,
  output logic               any_req
);

  int idx;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    grant   = last_grant;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!any_req && req[idx]) begin
        grant   = REQ_W'(idx);
        any_req = 1'b1;
      end else begin
        any_req = any_req;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/byte_striping_ctrl.sv
// Sequencer/arbiter in front of the 4-lane TX byte striper. Shares one
// striper byte input between NUM_REQ sources, locks the grant for a whole
// packet and pads partial groups so every packet ends on lane 3.
module byte_striping_ctrl
  import byte_striping_pkg::*;
#(
  parameter int         NUM_REQ  = 2,
  parameter int         LANES    = LANES_DEF,
  parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF,
  parameter int         REQ_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 stripe_valid,
  output logic [7:0]           stripe_data,
  output logic [1:0]           lane_ptr,
  output logic                 group_done,
  output logic [REQ_W-1:0]     grant_id,
  output logic                 busy
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [REQ_W-1:0]    grant_q, grant_d;
  logic                stripe_valid_q, stripe_valid_d;
  logic [7:0]          stripe_data_q, stripe_data_d;
  logic [LANE_W-1:0]   lane_ptr_q, lane_ptr_d;
  logic                group_done_q, group_done_d;

  logic [REQ_W-1:0]    arb_grant;
  logic                arb_any;
  logic                sel_valid;
  logic [7:0]          sel_data;
  logic                sel_last;
  logic                accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (grant_q),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  // Route the granted source's valid/data/last; other sources are ignored.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 8'h00;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == REQ_W'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[8*i +: 8];
        sel_last  = req_last[i];
      end else begin
        sel_valid = sel_valid;
      end
    end
  end

  // Ready is decoded from registered state only, never from req_valid.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_q == ST_STREAM) && (grant_q == REQ_W'(i))) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  assign accept = (state_q == ST_STREAM) && sel_valid;

  // Next-state and datapath: arbitrate in IDLE, forward in STREAM, fill in PAD.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    grant_d        = grant_q;
    stripe_valid_d = 1'b0;
    stripe_data_d  = stripe_data_q;
    lane_ptr_d     = lane_ptr_q;
    group_done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (accept) begin
          stripe_valid_d = 1'b1;
          stripe_data_d  = sel_data;
          lane_ptr_d     = wr_ptr_q;
          wr_ptr_d       = wr_ptr_q + 2'd1;
          group_done_d   = (wr_ptr_q == LAST_LANE);
          if (sel_last) begin
            state_d = (wr_ptr_q == LAST_LANE) ? ST_IDLE : ST_PAD;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_PAD: begin
        stripe_valid_d = 1'b1;
        stripe_data_d  = PAD_BYTE;
        lane_ptr_d     = wr_ptr_q;
        wr_ptr_d       = wr_ptr_q + 2'd1;
        if (wr_ptr_q == LAST_LANE) begin
          group_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_PAD;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_ptr_d = '0;
      end
    endcase
  end

  // State and registered outputs; async reset drops any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      grant_q        <= REQ_W'(NUM_REQ - 1);
      stripe_valid_q <= 1'b0;
      stripe_data_q  <= 8'h00;
      lane_ptr_q     <= '0;
      group_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      grant_q        <= grant_d;
      stripe_valid_q <= stripe_valid_d;
      stripe_data_q  <= stripe_data_d;
      lane_ptr_q     <= lane_ptr_d;
      group_done_q   <= group_done_d;
    end
  end

  assign stripe_valid = stripe_valid_q;
  assign stripe_data  = stripe_data_q;
  assign lane_ptr     = lane_ptr_q;
  assign group_done   = group_done_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != ST_IDLE);

endmodule : byte_striping_ctrl

// File: tb/tb_byte_striping_ctrl.sv
// Directed testbench for byte_striping_ctrl (NUM_REQ=2).
module tb_byte_striping_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        stripe_valid;
  logic [7:0]  stripe_data;
  logic [1:0]  lane_ptr;
  logic        group_done;
  logic [0:0]  grant_id;
  logic        busy;

  int checks = 0;
  int passed = 0;

  byte_striping_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .stripe_valid (stripe_valid),
    .stripe_data  (stripe_data),
    .lane_ptr     (lane_ptr),
    .group_done   (group_done),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    req_data  = 16'h0000;
    req_last  = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    req_last  = 2'b00;
    #17;
    checks++; if (stripe_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", stripe_valid); else passed++;
    checks++; if (stripe_data !== 8'h00) $display("FAIL rst_data: got %h exp 00", stripe_data); else passed++;
    checks++; if (lane_ptr !== 2'd0) $display("FAIL rst_lane: got %0d exp 0", lane_ptr); else passed++;
    checks++; if (group_done !== 1'b0) $display("FAIL rst_gd: got %b exp 0", group_done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else passed++;
    checks++; if (grant_id !== 1'b1) $display("FAIL rst_grant: got %0d exp 1", grant_id); else passed++;
    checks++; if (req_ready !== 2'b00) $display("FAIL rst_ready: got %b exp 00", req_ready); else passed++;
    reset = 1'b1;
    tick();
  endtask

  // One packet from a single source, including pad and return to IDLE.
  task automatic test_packet(input int src, input logic [7:0] base, input int len);
    int last_lane;
    req_valid = 2'b00;
    req_last  = 2'b00;
    req_valid[src] = 1'b1;
    req_data[src*8 +: 8] = base;
    req_last[src] = (len == 1);
    checks++; if (req_ready !== 2'b00) $display("FAIL idle_ready src%0d: got %b exp 00", src, req_ready); else passed++;
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL arb_busy: got %b exp 1", busy); else passed++;
    checks++; if (grant_id !== 1'(src)) $display("FAIL arb_grant: got %0d exp %0d", grant_id, src); else passed++;
    checks++; if (req_ready !== (2'b01 << src)) $display("FAIL arb_ready: got %b exp %b", req_ready, 2'b01 << src); else passed++;
    checks++; if (stripe_valid !== 1'b0) $display("FAIL arb_valid: got %b exp 0", stripe_valid); else passed++;
    for (int k = 0; k < len; k++) begin
      req_data[src*8 +: 8] = base + 8'(k);
      req_last[src] = (k == len - 1);
      tick();
      checks++; if (stripe_valid !== 1'b1) $display("FAIL data_valid k%0d: got %b exp 1", k, stripe_valid); else passed++;
      checks++; if (stripe_data !== base + 8'(k)) $display("FAIL data k%0d: got %h exp %h", k, stripe_data, base + 8'(k)); else passed++;
      checks++; if (lane_ptr !== 2'(k % 4)) $display("FAIL data_lane k%0d: got %0d exp %0d", k, lane_ptr, k % 4); else passed++;
      checks++; if (group_done !== (k % 4 == 3)) $display("FAIL data_gd k%0d: got %b exp %b", k, group_done, (k % 4 == 3)); else passed++;
    end
    req_valid = 2'b00;
    req_last  = 2'b00;
    last_lane = (len - 1) % 4;
    for (int j = last_lane + 1; j <= 3; j++) begin
      checks++; if (req_ready !== 2'b00) $display("FAIL pad_ready lane%0d: got %b exp 00", j, req_ready); else passed++;
      checks++; if (busy !== 1'b1) $display("FAIL pad_busy lane%0d: got %b exp 1", j, busy); else passed++;
      tick();
      checks++; if (stripe_valid !== 1'b1) $display("FAIL pad_valid lane%0d: got %b exp 1", j, stripe_valid); else passed++;
      checks++; if (stripe_data !== 8'hBC) $display("FAIL pad_data lane%0d: got %h exp bc", j, stripe_data); else passed++;
      checks++; if (lane_ptr !== 2'(j)) $display("FAIL pad_lane: got %0d exp %0d", lane_ptr, j); else passed++;
      checks++; if (group_done !== (j == 3)) $display("FAIL pad_gd lane%0d: got %b exp %b", j, group_done, (j == 3)); else passed++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL end_busy: got %b exp 0", busy); else passed++;
    tick();
    checks++; if (stripe_valid !== 1'b0) $display("FAIL end_valid: got %b exp 0", stripe_valid); else passed++;
  endtask

  task automatic test_single_source();
    test_packet(0, 8'h01, 8);
  endtask

  task automatic test_pad();
    test_packet(0, 8'hA0, 5);
  endtask

  task automatic test_one_byte();
    test_packet(0, 8'h55, 1);
  endtask

  // Both sources request continuously, two 4-byte packets each.
  task automatic test_round_robin();
    logic [7:0] exp_stream [16];
    logic [0:0] exp_grant [4];
    logic [0:0] gseq [4];
    int cnt [2];
    int nout, ng, idle_cycles, accepts;
    logic [1:0] rdy;
    logic prev_busy, started;
    exp_stream = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
                   8'h14, 8'h15, 8'h16, 8'h17, 8'h24, 8'h25, 8'h26, 8'h27};
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
    gseq = '{1'b1, 1'b0, 1'b1, 1'b0};
    cnt = '{0, 0};
    nout = 0; ng = 0; idle_cycles = 0; accepts = 0; started = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 60 && nout < 16; cyc++) begin
      for (int s = 0; s < 2; s++) begin
        req_valid[s] = (cnt[s] < 8);
        req_data[s*8 +: 8] = (s == 0 ? 8'h10 : 8'h20) + 8'(cnt[s]);
        req_last[s] = (cnt[s] % 4 == 3);
      end
      rdy = req_ready;
      prev_busy = busy;
      tick();
      for (int s = 0; s < 2; s++) begin
        if (rdy[s] && req_valid[s]) begin
          cnt[s]++;
          accepts++;
        end
      end
      if (busy && !prev_busy) begin
        started = 1'b1;
        if (ng < 4) gseq[ng] = grant_id;
        ng++;
      end
      if (!busy && started && accepts < 16) idle_cycles++;
      if (stripe_valid) begin
        checks++; if (stripe_data !== exp_stream[nout]) $display("FAIL rr_data n%0d: got %h exp %h", nout, stripe_data, exp_stream[nout]); else passed++;
        checks++; if (lane_ptr !== 2'(nout % 4)) $display("FAIL rr_lane n%0d: got %0d exp %0d", nout, lane_ptr, nout % 4); else passed++;
        nout++;
      end
    end
    req_valid = 2'b00;
    req_last  = 2'b00;
    checks++; if (nout !== 16) $display("FAIL rr_count: got %0d bytes exp 16 (timeout)", nout); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (gseq[i] !== exp_grant[i]) $display("FAIL rr_grant p%0d: got %0d exp %0d", i, gseq[i], exp_grant[i]); else passed++;
    end
    checks++; if (idle_cycles !== 3) $display("FAIL rr_idle_gaps: got %0d exp 3", idle_cycles); else passed++;
    tick();
  endtask

  // Source 1 granted, drops valid mid-packet while source 0 waits.
  task automatic test_bubbles();
    logic       v1 [6];
    logic [7:0] d1 [6];
    logic       l1 [6];
    logic [1:0] el [6];
    logic       eg [6];
    int waited;
    v1 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    d1 = '{8'h31, 8'h31, 8'h31, 8'h32, 8'h33, 8'h34};
    l1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    el = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    eg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    req_valid = 2'b10;
    req_data  = 16'h3100;
    req_last  = 2'b00;
    tick();
    checks++; if (grant_id !== 1'b1) $display("FAIL bub_grant1: got %0d exp 1", grant_id); else passed++;
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h77;
    req_last[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (req_ready !== 2'b10) $display("FAIL bub_ready c%0d: got %b exp 10", i, req_ready); else passed++;
      req_valid[1] = v1[i];
      req_data[15:8] = d1[i];
      req_last[1] = l1[i];
      tick();
      checks++; if (stripe_valid !== v1[i]) $display("FAIL bub_valid c%0d: got %b exp %b", i, stripe_valid, v1[i]); else passed++;
      checks++; if (stripe_data !== d1[i]) $display("FAIL bub_data c%0d: got %h exp %h", i, stripe_data, d1[i]); else passed++;
      checks++; if (group_done !== eg[i]) $display("FAIL bub_gd c%0d: got %b exp %b", i, group_done, eg[i]); else passed++;
      if (v1[i]) begin
        checks++; if (lane_ptr !== el[i]) $display("FAIL bub_lane c%0d: got %0d exp %0d", i, lane_ptr, el[i]); else passed++;
      end
    end
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL bub_idle: got %b exp 0", busy); else passed++;
    tick();
    checks++; if (grant_id !== 1'b0) $display("FAIL bub_grant0: got %0d exp 0", grant_id); else passed++;
    checks++; if (req_ready !== 2'b01) $display("FAIL bub_ready0: got %b exp 01", req_ready); else passed++;
    tick();
    checks++; if (stripe_data !== 8'h77 || lane_ptr !== 2'd0) $display("FAIL bub_src0: got %h/lane%0d exp 77/lane0", stripe_data, lane_ptr); else passed++;
    req_valid = 2'b00;
    req_last  = 2'b00;
    waited = 0;
    while (busy && waited < 10) begin
      tick();
      waited++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL bub_drain: got busy=%b exp 0 (timeout)", busy); else passed++;
    tick();
  endtask

  // Async reset while PAD is in progress; leftover pads must not appear.
  task automatic test_async_reset();
    int seen;
    req_valid = 2'b01;
    req_data  = 16'h0066;
    req_last  = 2'b01;
    tick();
    tick();
    req_valid = 2'b00;
    req_last  = 2'b00;
    tick();
    checks++; if (stripe_data !== 8'hBC || lane_ptr !== 2'd1) $display("FAIL ar_pre: got %h/lane%0d exp bc/lane1", stripe_data, lane_ptr); else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (stripe_valid !== 1'b0) $display("FAIL ar_valid: got %b exp 0", stripe_valid); else passed++;
    checks++; if (stripe_data !== 8'h00) $display("FAIL ar_data: got %h exp 00", stripe_data); else passed++;
    checks++; if (lane_ptr !== 2'd0) $display("FAIL ar_lane: got %0d exp 0", lane_ptr); else passed++;
    checks++; if (busy !== 1'b0 || group_done !== 1'b0) $display("FAIL ar_busy_gd: got %b%b exp 00", busy, group_done); else passed++;
    checks++; if (grant_id !== 1'b1) $display("FAIL ar_grant: got %0d exp 1", grant_id); else passed++;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (stripe_valid) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL ar_no_pads: got %0d valid cycles exp 0", seen); else passed++;
    test_packet(0, 8'h99, 1);
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_pad();
    test_one_byte();
    test_round_robin();
    test_bubbles();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_byte_striping_ctrl
